mem_io_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller between the CPU data bus and the on-chip data RAM and character screen RAM; next generation of the fixed-map memory I/O block. Adds a req/ack handshake, a registered read path, a control/status region, sticky decode-error reporting and an optional hardware screen-fill engine. The VGA scan-out port keeps independent, read-only access to the screen RAM.

---
 rtl/mem_io_pkg.sv | 21 ++
 rtl/mem_io_ctrl_if.sv | 22 ++
 rtl/mem_io_ctrl_fill.sv | 63 ++++++
 rtl/mem_io_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_io_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory-mapped I/O controller.
package mem_io_pkg;

  // Region select taken from memaddr[14:13]
  typedef enum logic [1:0] {
    REG_UNMAP  = 2'b00,
    REG_DATA   = 2'b01,
    REG_SCREEN = 2'b10,
    REG_CTRL   = 2'b11
  } region_e;

  // Register offsets inside the CTRL region (memaddr[1:0])
  localparam logic [1:0] CTRL_FILL   = 2'd0;
  localparam logic [1:0] CTRL_ERRCLR = 2'd1;

  typedef enum logic {
    FILL_IDLE,
    FILL_RUN
  } fill_state_e;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side bus of mem_io_ctrl: req/ack handshake, registered read return, status.
interface mem_io_ctrl_if;
  logic        req;
  logic        f_memwrite;
  logic [31:0] memaddr;
  logic [31:0] writedata;
  logic        ack;
  logic [31:0] readdata;
  logic        rvalid;
  logic        fill_busy;
  logic        dec_err;

  modport master (
    output req, f_memwrite, memaddr, writedata,
    input  ack, readdata, rvalid, fill_busy, dec_err
  );

  modport slave (
    input  req, f_memwrite, memaddr, writedata,
    output ack, readdata, rvalid, fill_busy, dec_err
  );
endinterface

// File: rtl/mem_io_ctrl_fill.sv
// screen_fill_fsm: walks every screen cell once, writing a latched fill code.
// Only instantiated when MEMIO_FILL_EN is defined.
module screen_fill_fsm
  import mem_io_pkg::*;
#(
  parameter int SCR_AW = 11,
  parameter int CODE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CODE_W-1:0] code_i,
  output logic              busy_o,
  output logic              we_o,
  output logic [SCR_AW-1:0] addr_o,
  output logic [CODE_W-1:0] code_o
);

  fill_state_e       state_q, state_d;
  logic [SCR_AW-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;

  // State, cell counter and latched fill code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  // Next state: one cell per cycle; the counter wraps to 0 after the last cell
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    we_o    = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (start_i) begin
          state_d = FILL_RUN;
          cnt_d   = '0;
          code_d  = code_i;
        end
      end
      FILL_RUN: begin
        we_o  = 1'b1;
        cnt_d = cnt_q + SCR_AW'(1);
        if (&cnt_q) state_d = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  assign busy_o = (state_q == FILL_RUN);
  assign addr_o = cnt_q;
  assign code_o = code_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: CPU bus to data RAM / screen RAM / control registers, with an
// independent read-only VGA scan-out port. Optional fill engine: MEMIO_FILL_EN.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int DATA_AW = 13,
  parameter int SCR_AW  = 11,
  parameter int CODE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_io_ctrl_if.slave      bus,
  input  logic [SCR_AW-1:0] vga_addr_i,
  output logic [CODE_W-1:0] vga_code_o
);

  region_e            region;
  logic [1:0]         ctrl_off;
  logic [DATA_AW-1:0] data_idx;
  logic [SCR_AW-1:0]  scr_idx;
  logic               stall, acc, acc_wr, acc_rd;

  logic               fill_busy, fill_we;
  logic [SCR_AW-1:0]  fill_addr;
  logic [CODE_W-1:0]  fill_code;

  logic               scr_we;
  logic [SCR_AW-1:0]  scr_waddr;
  logic [CODE_W-1:0]  scr_wdata;

  logic [31:0]        readdata_q, readdata_d;
  logic               rvalid_q;
  logic               dec_err_q, dec_err_d;
  logic [CODE_W-1:0]  vga_code_q;

  logic [31:0]        data_mem [2**DATA_AW];
  logic [CODE_W-1:0]  scr_mem  [2**SCR_AW];

  logic               unused_addr;
  assign unused_addr = ^bus.memaddr[31:15];

  assign region   = region_e'(bus.memaddr[14:13]);
  assign ctrl_off = bus.memaddr[1:0];
  assign data_idx = bus.memaddr[DATA_AW-1:0];
  assign scr_idx  = bus.memaddr[SCR_AW-1:0];

  // Screen and CTRL share the screen write port with the fill engine, so they wait
  assign stall  = fill_busy & ((region == REG_SCREEN) | (region == REG_CTRL));
  assign acc    = bus.req & ~stall;
  assign acc_wr = acc & bus.f_memwrite;
  assign acc_rd = acc & ~bus.f_memwrite;

`ifdef MEMIO_FILL_EN
  logic fill_start;
  assign fill_start = acc_wr & (region == REG_CTRL) & (ctrl_off == CTRL_FILL);

  screen_fill_fsm #(.SCR_AW(SCR_AW), .CODE_W(CODE_W)) u_fill (
    .clk     (clk),
    .rst     (rst),
    .start_i (fill_start),
    .code_i  (bus.writedata[CODE_W-1:0]),
    .busy_o  (fill_busy),
    .we_o    (fill_we),
    .addr_o  (fill_addr),
    .code_o  (fill_code)
  );
`else
  assign fill_busy = 1'b0;
  assign fill_we   = 1'b0;
  assign fill_addr = '0;
  assign fill_code = '0;
`endif

  // A CPU screen write can never coincide with a fill write (it is stalled)
  assign scr_we    = fill_we | (acc_wr & (region == REG_SCREEN));
  assign scr_waddr = fill_we ? fill_addr : scr_idx;
  assign scr_wdata = fill_we ? fill_code : bus.writedata[CODE_W-1:0];

  // Data RAM write port
  always_ff @(posedge clk) begin
    if (acc_wr && region == REG_DATA) data_mem[data_idx] <= bus.writedata;
  end

  // Screen RAM write port (CPU or fill engine)
  always_ff @(posedge clk) begin
    if (scr_we) scr_mem[scr_waddr] <= scr_wdata;
  end

  // Read return mux and sticky decode-error next state
  always_comb begin
    readdata_d = readdata_q;
    dec_err_d  = dec_err_q;
    if (acc_rd) begin
      case (region)
        REG_DATA:   readdata_d = data_mem[data_idx];
        REG_SCREEN: readdata_d = 32'(scr_mem[scr_idx]);
        REG_CTRL:   readdata_d = {30'b0, dec_err_q, fill_busy};
        default:    readdata_d = '0;
      endcase
    end
    if (acc && region == REG_UNMAP)                               dec_err_d = 1'b1;
    else if (acc_wr && region == REG_CTRL && ctrl_off == CTRL_ERRCLR) dec_err_d = 1'b0;
  end

  // Registered read path, status and VGA scan-out (old value on same-address write)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      dec_err_q  <= 1'b0;
      vga_code_q <= '0;
    end else begin
      readdata_q <= readdata_d;
      rvalid_q   <= acc_rd;
      dec_err_q  <= dec_err_d;
      vga_code_q <= scr_mem[vga_addr_i];
    end
  end

  assign bus.ack       = acc;
  assign bus.readdata  = readdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.fill_busy = fill_busy;
  assign bus.dec_err   = dec_err_q;
  assign vga_code_o    = vga_code_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl; fill-engine scenarios run when MEMIO_FILL_EN is defined.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] vga_addr = '0;
  logic [7:0]  vga_code;

  int n_chk  = 0;
  int n_fail = 0;
  int last_wait;
  int busy_cnt = 0;

  mem_io_ctrl_if bus();

  mem_io_ctrl #(.DATA_AW(13), .SCR_AW(11), .CODE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .vga_addr_i (vga_addr),
    .vga_code_o (vga_code)
  );

  always #5 clk = ~clk;

  // Number of cycles fill_busy was high, sampled mid-cycle
  always @(negedge clk) if (bus.fill_busy === 1'b1) busy_cnt <= busy_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus access; returns at acceptance edge + 1 time unit, last_wait = stalled cycles
  task automatic bus_acc(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.req = 1'b1; bus.f_memwrite = we; bus.memaddr = addr; bus.writedata = wd;
    #1;
    last_wait = 0;
    while (bus.ack !== 1'b1 && last_wait < 5000) begin
      @(negedge clk); #1; last_wait++;
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic vga_rd(input logic [10:0] a, output logic [7:0] c);
    @(negedge clk); vga_addr = a;
    @(posedge clk); #1; c = vga_code;
  endtask

  task automatic wait_fill_end();
    for (int k = 0; k < 5000 && bus.fill_busy === 1'b1; k++) @(negedge clk);
  endtask

  initial begin
    logic [7:0] c;
    int b0, bad;
    bus.req = 1'b0; bus.f_memwrite = 1'b0; bus.memaddr = '0; bus.writedata = '0;

    // Reset state
    #23;
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_rvalid",   {31'b0, bus.rvalid}, 32'h0);
    check("rst_dec_err",  {31'b0, bus.dec_err}, 32'h0);
    check("rst_fill_busy",{31'b0, bus.fill_busy}, 32'h0);
    check("rst_vga_code", {24'b0, vga_code}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // DATA write then read
    bus_acc(1'b1, 32'h2004, 32'hDEADBEEF);
    check("data_wr_wait", last_wait, 0);
    bus_acc(1'b0, 32'h2004, 32'h0);
    check("data_rd_wait", last_wait, 0);
    check("data_rd_rvalid", {31'b0, bus.rvalid}, 32'h1);
    check("data_rd_val", bus.readdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("rvalid_pulse", {31'b0, bus.rvalid}, 32'h0);
    check("readdata_hold", bus.readdata, 32'hDEADBEEF);

    // Top DATA word
    bus_acc(1'b1, 32'h3FFF, 32'hA5A55A5A);
    bus_acc(1'b0, 32'h3FFF, 32'h0);
    check("data_top_val", bus.readdata, 32'hA5A55A5A);

    // SCREEN write truncates to the code width, read zero-extends
    bus_acc(1'b1, 32'h4010, 32'h141);
    bus_acc(1'b0, 32'h4010, 32'h0);
    check("scr_rd_val", bus.readdata, 32'h41);
    vga_rd(11'h010, c);
    check("vga_code", {24'b0, c}, 32'h41);

    // Unmapped access, status read, error clear
    bus_acc(1'b0, 32'h0100, 32'h0);
    check("unmap_rvalid", {31'b0, bus.rvalid}, 32'h1);
    check("unmap_rd_val", bus.readdata, 32'h0);
    check("unmap_dec_err", {31'b0, bus.dec_err}, 32'h1);
    bus_acc(1'b0, 32'h6000, 32'h0);
    check("ctrl_status", bus.readdata, 32'h2);
    bus_acc(1'b1, 32'h6001, 32'h0);
    check("errclr", {31'b0, bus.dec_err}, 32'h0);
    bus_acc(1'b1, 32'h6002, 32'h0);
    check("ctrl_off2_ignored", {31'b0, bus.dec_err}, 32'h0);

`ifdef MEMIO_FILL_EN
    // Fill with 0x20; DATA read during the fill, SCREEN write stalled until the end
    bus_acc(1'b1, 32'h6000, 32'h20);
    check("fill_start_wait", last_wait, 0);
    check("fill_busy_rise", {31'b0, bus.fill_busy}, 32'h1);
    b0 = busy_cnt;
    bus_acc(1'b0, 32'h2004, 32'h0);
    check("fill_data_rd_wait", last_wait, 0);
    check("fill_data_rd_val", bus.readdata, 32'hDEADBEEF);
    bus_acc(1'b0, 32'h6000, 32'h0);
    check("fill_ctrl_rd_stalled", {31'b0, bus.fill_busy}, 32'h0);
    check("fill_ctrl_rd_val", bus.readdata, 32'h0);
    check("fill_busy_cycles", busy_cnt - b0, 2048);
    b0 = 0;
    bus_acc(1'b1, 32'h6000, 32'h20);
    b0 = busy_cnt;
    repeat (50) @(posedge clk);
    @(negedge clk);
    bus.req = 1'b1; bus.f_memwrite = 1'b1; bus.memaddr = 32'h4020; bus.writedata = 32'h77;
    #1;
    check("scr_wr_stalled", {31'b0, bus.ack}, 32'h0);
    last_wait = 0;
    while (bus.ack !== 1'b1 && last_wait < 5000) begin
      @(negedge clk); #1; last_wait++;
    end
    check("scr_wr_ack_after_fill", {31'b0, bus.fill_busy}, 32'h0);
    @(posedge clk); #1; bus.req = 1'b0;
    check("refill_busy_cycles", busy_cnt - b0, 2048);
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      vga_rd(11'(i), c);
      if (c !== ((i == 32) ? 8'h77 : 8'h20)) bad++;
    end
    check("fill_cells_bad", bad, 0);
    bus_acc(1'b0, 32'h47FF, 32'h0);
    check("fill_last_cell", bus.readdata, 32'h20);

    // Reset in the middle of a fill
    bus_acc(1'b1, 32'h41F4, 32'h33);
    bus_acc(1'b1, 32'h0000, 32'h0);
    bus_acc(1'b0, 32'h2004, 32'h0);
    bus_acc(1'b1, 32'h6000, 32'h5A);
    repeat (500) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_fill_busy", {31'b0, bus.fill_busy}, 32'h0);
    check("midrst_dec_err", {31'b0, bus.dec_err}, 32'h0);
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_vga_code", {24'b0, vga_code}, 32'h0);
    @(negedge clk); rst = 1'b0;
    vga_rd(11'd0, c);   check("midrst_cell0",   {24'b0, c}, 32'h5A);
    vga_rd(11'd499, c); check("midrst_cell499", {24'b0, c}, 32'h5A);
    vga_rd(11'd500, c); check("midrst_cell500", {24'b0, c}, 32'h33);
    vga_rd(11'd501, c); check("midrst_cell501", {24'b0, c}, 32'h20);

    // Full fill after reset
    bus_acc(1'b1, 32'h6000, 32'h11);
    b0 = busy_cnt;
    wait_fill_end();
    check("postrst_fill_done", {31'b0, bus.fill_busy}, 32'h0);
    check("postrst_busy_cycles", busy_cnt - b0, 2048);
    vga_rd(11'd500, c);  check("postrst_cell500",  {24'b0, c}, 32'h11);
    vga_rd(11'd2047, c); check("postrst_cell2047", {24'b0, c}, 32'h11);
`else
    // Without the fill engine, a fill command is acked and does nothing
    bus_acc(1'b1, 32'h47FF, 32'h3C);
    bus_acc(1'b1, 32'h6000, 32'h99);
    check("nofill_ack", last_wait, 0);
    check("nofill_busy", {31'b0, bus.fill_busy}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("nofill_busy_later", {31'b0, bus.fill_busy}, 32'h0);
    vga_rd(11'h010, c);  check("nofill_cell010", {24'b0, c}, 32'h41);
    vga_rd(11'h7FF, c);  check("nofill_cell7ff", {24'b0, c}, 32'h3C);
    bus_acc(1'b1, 32'h0000, 32'h0);
    bus_acc(1'b0, 32'h6003, 32'h0);
    check("nofill_status", bus.readdata, 32'h2);
    #2 rst = 1'b1;
    #1;
    check("rst_clears_dec_err", {31'b0, bus.dec_err}, 32'h0);
    check("rst_clears_readdata", bus.readdata, 32'h0);
    @(negedge clk); rst = 1'b0;
    bus_acc(1'b0, 32'h2004, 32'h0);
    check("ram_kept_over_rst", bus.readdata, 32'hDEADBEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
